// File: rtl/systolic_sequencer_if.sv
// -----------------------------------------------------------------------------
// systolic_sequencer_if
// Bundles every signal between the systolic sequencer and its surroundings:
// the controller (start/busy/done), the A/B operand buffers, the PE array
// edges and control, and the C result buffer.
//
// Modports
//   slave  : the sequencer itself (takes start and buffer/array return data,
//            drives everything else)
//   master : the environment around it (controller, buffers, PE array)
//
// Signals
//   start       controller -> seq   level request, taken only when idle
//   busy, done  seq -> controller   run status
//   rd_en, rd_k seq -> A/B buffers  read strobe and k index
//   a_col_data  A buffer -> seq     A[i][k] in lane i, one cycle after rd_en
//   b_row_data  B buffer -> seq     B[k][j] in lane j, one cycle after rd_en
//   a_feed      seq -> array        west-edge operands, lane i = row i
//   b_feed      seq -> array        north-edge operands, lane j = col j
//   pe_clear    seq -> array        zero all accumulators
//   pe_en       seq -> array        shift + MAC enable
//   c_row_sel   seq -> array        result row select
//   c_row_data  array -> seq        selected result row, lane j = C[r][j]
//   c_wr_en     seq -> C buffer     write strobe
//   c_wr_addr   seq -> C buffer     row address
//   c_wr_data   seq -> C buffer     row data
// -----------------------------------------------------------------------------
interface systolic_sequencer_if #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int ACCW = 2*DW + $clog2(N),
  parameter int KW   = $clog2(N)
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [KW-1:0]     rd_k;
  logic [N*DW-1:0]   a_col_data;
  logic [N*DW-1:0]   b_row_data;
  logic [N*DW-1:0]   a_feed;
  logic [N*DW-1:0]   b_feed;
  logic              pe_clear;
  logic              pe_en;
  logic [KW-1:0]     c_row_sel;
  logic [N*ACCW-1:0] c_row_data;
  logic              c_wr_en;
  logic [KW-1:0]     c_wr_addr;
  logic [N*ACCW-1:0] c_wr_data;

  modport slave (
    input  start, a_col_data, b_row_data, c_row_data,
    output busy, done, rd_en, rd_k, a_feed, b_feed, pe_clear, pe_en,
           c_row_sel, c_wr_en, c_wr_addr, c_wr_data
  );

  modport master (
    output start, a_col_data, b_row_data, c_row_data,
    input  busy, done, rd_en, rd_k, a_feed, b_feed, pe_clear, pe_en,
           c_row_sel, c_wr_en, c_wr_addr, c_wr_data
  );
endinterface

// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
// Runs one NxN matrix multiply C = A*B on an output-stationary systolic array.
// Reads one A column / B row per cycle, skews the lanes onto the array edges,
// clears and enables the PEs, then drains the accumulators row by row into
// the C buffer. Data is passed through untouched; no arithmetic happens here.
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (aborts a run immediately)
//   bus  systolic_sequencer_if.slave, see the interface for signal list
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   stIdle   | waiting for start
//   stClear  | 1 cycle: pe_clear, skew registers zeroed
//   stFeed   | 3N-1 cycles: reads k=0..N-1, skewed lanes feed the PEs
//   stDrain  | N+1 cycles: select rows 0..N-1, registered writes to C
//   stDone   | 1 cycle: done pulse, busy still high
// -----------------------------------------------------------------------------
module systolic_sequencer #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int ACCW = 2*DW + $clog2(N),
  parameter int KW   = $clog2(N)
) (
  input logic                 clk,
  input logic                 rst,
  systolic_sequencer_if.slave bus
);

  // Counter must reach 3N-2 (last FEED cycle).
  localparam int CW = $clog2(3*N);
  localparam logic [CW-1:0] FEED_LAST  = CW'(3*N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N);
  localparam logic [CW-1:0] DIM        = CW'(N);

  typedef enum logic [2:0] {
    stIdle  = 3'd0,
    stClear = 3'd1,
    stFeed  = 3'd2,
    stDrain = 3'd3,
    stDone  = 3'd4
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [CW-1:0]     cyc;

  logic              readActive;
  logic              drainSel;
  logic [KW-1:0]     rowSel;
  logic              rdValid;

  logic              cWrEn;
  logic [KW-1:0]     cWrAddr;
  logic [N*ACCW-1:0] cWrData;

  logic [N*DW-1:0]   aFeedVec;
  logic [N*DW-1:0]   bFeedVec;

  // ---------------------------------------------------------------------------
  // State register. cyc restarts at 0 on every state change, so FEED and
  // DRAIN both see a count that starts at their own first cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= stIdle;
      cyc   <= '0;
    end else begin
      state <= stateNext;
      if (stateNext != state) begin
        cyc <= '0;
      end else if (state == stFeed || state == stDrain) begin
        cyc <= cyc + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    case (state)
      stIdle:  if (bus.start) stateNext = stClear;
      stClear: stateNext = stFeed;
      stFeed:  if (cyc == FEED_LAST) stateNext = stDrain;
      stDrain: if (cyc == DRAIN_LAST) stateNext = stDone;
      stDone:  stateNext = stIdle;
      default: stateNext = stIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  assign readActive = (state == stFeed)  && (cyc < DIM);
  assign drainSel   = (state == stDrain) && (cyc < DIM);
  assign rowSel     = cyc[KW-1:0];

  always_comb begin
    bus.busy      = (state != stIdle);
    bus.done      = (state == stDone);
    bus.pe_clear  = (state == stClear);
    bus.pe_en     = (state == stFeed);
    bus.rd_en     = readActive;
    bus.rd_k      = '0;
    bus.c_row_sel = '0;
    if (readActive) bus.rd_k = rowSel;
    if (drainSel)   bus.c_row_sel = rowSel;
  end

  // ---------------------------------------------------------------------------
  // Read-return tracking and registered C write path. The row selected in
  // DRAIN cycle r is written in DRAIN cycle r+1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rdValid <= 1'b0;
      cWrEn   <= 1'b0;
      cWrAddr <= '0;
      cWrData <= '0;
    end else begin
      rdValid <= readActive;
      cWrEn   <= drainSel;
      cWrAddr <= drainSel ? rowSel : '0;
      cWrData <= drainSel ? bus.c_row_data : '0;
    end
  end

  assign bus.c_wr_en   = cWrEn;
  assign bus.c_wr_addr = cWrAddr;
  assign bus.c_wr_data = cWrData;

  // ---------------------------------------------------------------------------
  // Edge skew. Buffer data is gated by rdValid so that cycles with no read
  // push zeros (not whatever the buffer happens to drive) into the lanes.
  // Lane 0 goes straight through; lane i sits behind i registers.
  // ---------------------------------------------------------------------------
  assign aFeedVec[0 +: DW] = rdValid ? bus.a_col_data[0 +: DW] : '0;
  assign bFeedVec[0 +: DW] = rdValid ? bus.b_row_data[0 +: DW] : '0;

  for (genvar gi = 1; gi < N; gi++) begin : gSkew
    logic [DW-1:0] pipeA [gi];
    logic [DW-1:0] pipeB [gi];

    always_ff @(posedge clk) begin
      if (rst || state == stClear) begin
        for (int s = 0; s < gi; s++) begin
          pipeA[s] <= '0;
          pipeB[s] <= '0;
        end
      end else begin
        pipeA[0] <= rdValid ? bus.a_col_data[gi*DW +: DW] : '0;
        pipeB[0] <= rdValid ? bus.b_row_data[gi*DW +: DW] : '0;
        for (int s = 1; s < gi; s++) begin
          pipeA[s] <= pipeA[s-1];
          pipeB[s] <= pipeB[s-1];
        end
      end
    end

    assign aFeedVec[gi*DW +: DW] = pipeA[gi-1];
    assign bFeedVec[gi*DW +: DW] = pipeB[gi-1];
  end

  assign bus.a_feed = aFeedVec;
  assign bus.b_feed = bFeedVec;

endmodule

// File: tb/tb_systolic_sequencer.sv
module tb_systolic_sequencer;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int ACCW = 2*DW + $clog2(N);
  localparam int KW   = $clog2(N);
  localparam int RUNLEN = 4*N + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  systolic_sequencer_if #(.N(N), .DW(DW), .ACCW(ACCW), .KW(KW)) bus ();

  systolic_sequencer #(.N(N), .DW(DW), .ACCW(ACCW), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Operand matrices: A[i][k], B[k][j]
  logic [DW-1:0]   matA [N][N];
  logic [DW-1:0]   matB [N][N];
  logic [N*ACCW-1:0] lastRow;

  // A/B buffer: one-cycle read latency, random junk when not read.
  always @(posedge clk) begin
    for (int l = 0; l < N; l++) begin
      if (bus.rd_en) begin
        bus.a_col_data[l*DW +: DW] <= matA[l][bus.rd_k];
        bus.b_row_data[l*DW +: DW] <= matB[bus.rd_k][l];
      end else begin
        bus.a_col_data[l*DW +: DW] <= DW'($urandom);
        bus.b_row_data[l*DW +: DW] <= DW'($urandom);
      end
    end
  end

  // Output-stationary PE array: A moves east, B moves south.
  logic [DW-1:0]   peA [N][N];
  logic [DW-1:0]   peB [N][N];
  logic [ACCW-1:0] peAcc [N][N];

  always @(posedge clk) begin
    logic [DW-1:0] ain, bin;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (bus.pe_clear) begin
          peA[i][j]   <= '0;
          peB[i][j]   <= '0;
          peAcc[i][j] <= '0;
        end else if (bus.pe_en) begin
          ain = (j == 0) ? bus.a_feed[i*DW +: DW] : peA[i][j-1];
          bin = (i == 0) ? bus.b_feed[j*DW +: DW] : peB[i-1][j];
          peA[i][j]   <= ain;
          peB[i][j]   <= bin;
          peAcc[i][j] <= peAcc[i][j] + ACCW'(ain) * ACCW'(bin);
        end
      end
    end
  end

  always_comb begin
    bus.c_row_data = '0;
    for (int j = 0; j < N; j++) bus.c_row_data[j*ACCW +: ACCW] = peAcc[bus.c_row_sel][j];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full run from the start-sampling edge; every cycle is checked
  // against the schedule and C = A*B computed directly.
  task automatic runOnce(input bit hold, input string name);
    logic [ACCW-1:0]   refC [N][N];
    logic [N*ACCW-1:0] row;
    logic [DW-1:0]     expLane;
    int r, k, c;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        refC[i][j] = '0;
        for (int kk = 0; kk < N; kk++)
          refC[i][j] = refC[i][j] + ACCW'(matA[i][kk]) * ACCW'(matB[kk][j]);
      end

    bus.start = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
    for (int t = 1; t <= RUNLEN; t++) begin
      chk($sformatf("%s busy t%0d", name, t), bus.busy, 1'b1);
      chk($sformatf("%s done t%0d", name, t), bus.done, t == RUNLEN);
      chk($sformatf("%s pe_clear t%0d", name, t), bus.pe_clear, t == 1);
      chk($sformatf("%s pe_en t%0d", name, t), bus.pe_en, (t >= 2) && (t <= 3*N));
      chk($sformatf("%s rd_en t%0d", name, t), bus.rd_en, (t >= 2) && (t <= N+1));
      if (t >= 2 && t <= N+1) chk($sformatf("%s rd_k t%0d", name, t), bus.rd_k, t - 2);
      chk($sformatf("%s c_wr_en t%0d", name, t), bus.c_wr_en, (t >= 3*N+2) && (t <= 4*N+1));
      if (t >= 3*N+2 && t <= 4*N+1) begin
        r = t - (3*N+2);
        for (int j = 0; j < N; j++) row[j*ACCW +: ACCW] = refC[r][j];
        chk($sformatf("%s c_wr_addr t%0d", name, t), bus.c_wr_addr, r);
        chk($sformatf("%s c_wr_data row%0d", name, r), bus.c_wr_data, row);
        lastRow = bus.c_wr_data;
      end
      c = t - 2;
      for (int l = 0; l < N; l++) begin
        k = c - 1 - l;
        expLane = (c >= 0 && k >= 0 && k < N) ? matA[l][k] : '0;
        chk($sformatf("%s a_feed t%0d l%0d", name, t, l), bus.a_feed[l*DW +: DW], expLane);
        expLane = (c >= 0 && k >= 0 && k < N) ? matB[k][l] : '0;
        chk($sformatf("%s b_feed t%0d l%0d", name, t, l), bus.b_feed[l*DW +: DW], expLane);
      end
      step();
    end
    chk($sformatf("%s busy after", name), bus.busy, 1'b0);
    chk($sformatf("%s done after", name), bus.done, 1'b0);
    chk($sformatf("%s c_wr_en after", name), bus.c_wr_en, 1'b0);
  endtask

  task automatic setIdentity(input logic [DW-1:0] d);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        matA[i][j] = (i == j) ? d : '0;
        matB[i][j] = (i == j) ? d : '0;
      end
  endtask

  task automatic chkQuiet(input string tag);
    chk({tag, " busy"}, bus.busy, 1'b0);
    chk({tag, " done"}, bus.done, 1'b0);
    chk({tag, " rd_en"}, bus.rd_en, 1'b0);
    chk({tag, " pe_en"}, bus.pe_en, 1'b0);
    chk({tag, " pe_clear"}, bus.pe_clear, 1'b0);
    chk({tag, " c_wr_en"}, bus.c_wr_en, 1'b0);
    chk({tag, " c_wr_addr"}, bus.c_wr_addr, '0);
    chk({tag, " c_wr_data"}, bus.c_wr_data, '0);
    chk({tag, " a_feed"}, bus.a_feed, '0);
    chk({tag, " b_feed"}, bus.b_feed, '0);
    chk({tag, " rd_k"}, bus.rd_k, '0);
    chk({tag, " c_row_sel"}, bus.c_row_sel, '0);
  endtask

  initial begin
    bus.start = 1'b0;
    setIdentity(16'd0);

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chkQuiet("reset");

    // 1: A = I, B[k][j] = 4k+j+1
    setIdentity(16'd1);
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) matB[k][j] = DW'(4*k + j + 1);
    runOnce(1'b0, "ident");

    // 2: all ones, widest results
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        matA[i][j] = 16'hFFFF;
        matB[i][j] = 16'hFFFF;
      end
    runOnce(1'b0, "allOnes");
    chk("allOnes elem", lastRow[ACCW-1:0], 34'h3_FFF8_0004);

    // Random operands
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          matA[i][j] = DW'($urandom);
          matB[i][j] = DW'($urandom);
        end
      runOnce(1'b0, $sformatf("rand%0d", n));
    end

    // 4: start held high, back-to-back runs every RUNLEN+1 cycles
    runOnce(1'b1, "hold0");
    runOnce(1'b1, "hold1");
    bus.start = 1'b0;
    step();
    chk("hold end busy", bus.busy, 1'b0);

    // 5: reset in FEED cycle 5 (cycle 7 after start)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        matA[i][j] = DW'($urandom);
        matB[i][j] = DW'($urandom);
      end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int t = 1; t < 7; t++) step();
    chk("abort pe_en before", bus.pe_en, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chkQuiet("abort");
    for (int t = 0; t < 14; t++) begin
      step();
      chk($sformatf("abort idle c_wr_en %0d", t), bus.c_wr_en, 1'b0);
      chk($sformatf("abort idle done %0d", t), bus.done, 1'b0);
      chk($sformatf("abort idle busy %0d", t), bus.busy, 1'b0);
    end
    runOnce(1'b0, "afterAbort");

    // 6: residue from a previous run must be cleared
    setIdentity(16'd2);
    runOnce(1'b0, "twoI");
    setIdentity(16'd1);
    runOnce(1'b0, "oneI");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
